// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: per-stage enables/flushes, MDU occupancy FSM.
// Latency: outputs are combinational (Mealy) from FSM state and inputs; only the state, counter and perf counters are registered.
// Backpressure: a data-memory wait freezes everything up to EX/MEM; MDU and load-use stalls hold the front end. PIPE_CTRL_PERF_EN adds perf counters.
module pipe_hazard_ctrl #(
    parameter int REG_AW     = 5,
    parameter int MDU_CYCLES = 32,
    parameter int CNT_W      = 6,
    parameter int PERF_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] ex_rd_addr,
    input  logic              ex_branch_taken,
    input  logic              ex_mdu_start,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              idex_en,
    output logic              exmem_en,
    output logic              memwb_en,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              exmem_flush,
    output logic              memwb_flush,
    output logic              mdu_busy,
    output logic [PERF_W-1:0] perf_stall_cnt,
    output logic [PERF_W-1:0] perf_flush_cnt
);

    typedef enum logic {RUN = 1'b0, MDU_BUSY = 1'b1} state_t;

    state_t           state;
    logic [CNT_W-1:0] mdu_cnt;

    logic mem_wait;
    logic mdu_stall;
    logic load_use;
    logic branch_flush;

    assign mem_wait  = mem_req & ~mem_ready;
    assign mdu_stall = ((state == RUN) & ex_mdu_start) |
                       ((state == MDU_BUSY) & (mdu_cnt != '0));
    assign load_use  = ex_memread & (ex_rd_addr != '0) &
                       ((ex_rd_addr == id_rs) | (id_uses_rt & (ex_rd_addr == id_rt)));
    // A branch only squashes when EX is actually advancing.
    assign branch_flush = ~reset & ~mem_wait & ~mdu_stall & ex_branch_taken;
    assign mdu_busy     = (state == MDU_BUSY);

    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        if (!reset) begin
            if (mem_wait) begin
                memwb_en    = 1'b1;
                memwb_flush = 1'b1;
            end else if (mdu_stall) begin
                exmem_en    = 1'b1;
                exmem_flush = 1'b1;
                memwb_en    = 1'b1;
            end else if (ex_branch_taken) begin
                pc_en      = 1'b1;
                ifid_en    = 1'b1;
                idex_en    = 1'b1;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (load_use) begin
                idex_en    = 1'b1;
                idex_flush = 1'b1;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
            end else begin
                pc_en    = 1'b1;
                ifid_en  = 1'b1;
                idex_en  = 1'b1;
                exmem_en = 1'b1;
                memwb_en = 1'b1;
            end
        end
    end

    // The count runs through memory waits; only the final release waits for them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= RUN;
            mdu_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (ex_mdu_start) begin
                        mdu_cnt <= CNT_W'(MDU_CYCLES - 1);
                        state   <= MDU_BUSY;
                    end
                end
                MDU_BUSY: begin
                    if (mdu_cnt != '0) begin
                        mdu_cnt <= mdu_cnt - CNT_W'(1);
                    end else if (!mem_wait) begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [PERF_W-1:0] stall_q;
    logic [PERF_W-1:0] flush_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_en && (stall_q != '1)) begin
                stall_q <= stall_q + PERF_W'(1);
            end
            if (branch_flush && (flush_q != '1)) begin
                flush_q <= flush_q + PERF_W'(1);
            end
        end
    end

    assign perf_stall_cnt = stall_q;
    assign perf_flush_cnt = flush_q;
`else
    logic unused_perf;
    assign unused_perf    = branch_flush;
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus random traffic against a cycle-age reference model.
module tb_pipe_hazard_ctrl;

    localparam int REG_AW     = 5;
    localparam int MDU_CYCLES = 4;
    localparam int CNT_W      = 3;
    localparam int PERF_W     = 6;
    localparam int PERF_MAX   = (1 << PERF_W) - 1;
`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [REG_AW-1:0] id_rs, id_rt, ex_rd_addr;
    logic              id_uses_rt, ex_memread, ex_branch_taken, ex_mdu_start, mem_req, mem_ready;
    logic              pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic              ifid_flush, idex_flush, exmem_flush, memwb_flush, mdu_busy;
    logic [PERF_W-1:0] perf_stall_cnt, perf_flush_cnt;

    pipe_hazard_ctrl #(
        .REG_AW(REG_AW), .MDU_CYCLES(MDU_CYCLES), .CNT_W(CNT_W), .PERF_W(PERF_W)
    ) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_memread(ex_memread), .ex_rd_addr(ex_rd_addr),
        .ex_branch_taken(ex_branch_taken), .ex_mdu_start(ex_mdu_start),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
        .mdu_busy(mdu_busy), .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: an MDU op is "active" from the cycle after its start; m_age counts cycles since start.
    bit         m_active;
    int         m_age;
    int         m_stall;
    int         m_flush;
    logic [8:0] exp_vec;
    bit         exp_branch;
    wire  [8:0] act_vec = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                           ifid_flush, idex_flush, exmem_flush, memwb_flush};

    function automatic void model_eval();
        bit mw, ms, lu;
        mw = mem_req && !mem_ready;
        ms = m_active ? (m_age < MDU_CYCLES) : ex_mdu_start;
        lu = ex_memread && (ex_rd_addr != 0) &&
             ((ex_rd_addr == id_rs) || (id_uses_rt && (ex_rd_addr == id_rt)));
        exp_branch = 1'b0;
        if (mw)                   exp_vec = 9'b00001_0001;
        else if (ms)              exp_vec = 9'b00011_0010;
        else if (ex_branch_taken) begin exp_vec = 9'b11111_1100; exp_branch = 1'b1; end
        else if (lu)              exp_vec = 9'b00111_0100;
        else                      exp_vec = 9'b11111_0000;
    endfunction

    function automatic void model_advance();
        bit mw;
        mw = mem_req && !mem_ready;
        if (!exp_vec[8] && m_stall < PERF_MAX) m_stall++;
        if (exp_branch && m_flush < PERF_MAX)  m_flush++;
        if (m_active) begin
            if (m_age >= MDU_CYCLES && !mw) m_active = 1'b0;
            else                             m_age++;
        end else if (ex_mdu_start) begin
            m_active = 1'b1;
            m_age    = 1;
        end
    endfunction

    task automatic apply(input logic [REG_AW-1:0] rs, input logic [REG_AW-1:0] rt, input bit urt,
                         input bit mr, input logic [REG_AW-1:0] rd, input bit br, input bit st,
                         input bit mq, input bit mrdy);
        id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_memread = mr; ex_rd_addr = rd;
        ex_branch_taken = br; ex_mdu_start = st; mem_req = mq; mem_ready = mrdy;
        model_eval();
        #1;
    endtask

    task automatic tick();
        model_advance();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        m_active = 1'b0; m_age = 0; m_stall = 0; m_flush = 0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        apply(0, 0, 0, 0, 0, 0, 0, 0, 1);
        n_tests++; if (act_vec !== 9'b0) begin n_fail++; $display("FAIL reset_outs: got %b expected %b", act_vec, 9'b0); end
        n_tests++; if (mdu_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", mdu_busy); end
        n_tests++; if (perf_stall_cnt !== 0 || perf_flush_cnt !== 0) begin n_fail++;
            $display("FAIL reset_perf: got %0d/%0d expected 0/0", perf_stall_cnt, perf_flush_cnt); end
        do_reset();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 1);
        n_tests++; if (act_vec !== 9'b11111_0000) begin n_fail++; $display("FAIL post_reset_run: got %b expected %b", act_vec, 9'b11111_0000); end
    endtask

    task automatic test_load_use();
        apply(8, 3, 0, 1, 8, 0, 0, 0, 1);
        n_tests++; if (act_vec !== exp_vec || pc_en !== 1'b0 || idex_flush !== 1'b1) begin n_fail++;
            $display("FAIL load_use_rs: got %b expected %b", act_vec, exp_vec); end
        tick();
        apply(3, 9, 1, 1, 9, 0, 0, 0, 1);
        n_tests++; if (act_vec !== exp_vec || ifid_en !== 1'b0) begin n_fail++;
            $display("FAIL load_use_rt: got %b expected %b", act_vec, exp_vec); end
        tick();
        apply(3, 9, 0, 1, 9, 0, 0, 0, 1);
        n_tests++; if (act_vec !== exp_vec || pc_en !== 1'b1) begin n_fail++;
            $display("FAIL load_use_rt_unused: got %b expected %b", act_vec, exp_vec); end
        tick();
        apply(0, 0, 1, 1, 0, 0, 0, 0, 1);
        n_tests++; if (act_vec !== exp_vec || pc_en !== 1'b1) begin n_fail++;
            $display("FAIL load_use_r0: got %b expected %b", act_vec, exp_vec); end
        tick();
    endtask

    task automatic test_branch();
        apply(1, 2, 1, 0, 5, 1, 0, 0, 1);
        n_tests++; if (act_vec !== exp_vec || ifid_flush !== 1'b1 || idex_flush !== 1'b1) begin n_fail++;
            $display("FAIL branch: got %b expected %b", act_vec, exp_vec); end
        tick();
        apply(8, 2, 0, 1, 8, 1, 0, 0, 1);
        n_tests++; if (act_vec !== exp_vec || pc_en !== 1'b1) begin n_fail++;
            $display("FAIL branch_vs_load_use: got %b expected %b", act_vec, exp_vec); end
        tick();
        apply(1, 2, 0, 0, 5, 1, 0, 1, 0);
        n_tests++; if (act_vec !== exp_vec || ifid_flush !== 1'b0) begin n_fail++;
            $display("FAIL branch_in_mem_wait: got %b expected %b", act_vec, exp_vec); end
        tick();
    endtask

    task automatic test_mdu();
        int stalls;
        stalls = 0;
        for (int c = 0; c <= MDU_CYCLES; c++) begin
            apply(0, 0, 0, 0, 0, (c == 1), 1, 0, 1);
            if (pc_en === 1'b0) stalls++;
            n_tests++; if (act_vec !== exp_vec || mdu_busy !== m_active) begin n_fail++;
                $display("FAIL mdu_cycle%0d: got %b/%b expected %b/%b", c, act_vec, mdu_busy, exp_vec, m_active); end
            tick();
        end
        n_tests++; if (stalls != MDU_CYCLES) begin n_fail++;
            $display("FAIL mdu_stall_len: got %0d expected %0d", stalls, MDU_CYCLES); end
        apply(0, 0, 0, 0, 0, 0, 0, 0, 1);
        n_tests++; if (mdu_busy !== 1'b0 || pc_en !== 1'b1) begin n_fail++;
            $display("FAIL mdu_no_retrigger: got busy=%b pc_en=%b expected busy=0 pc_en=1", mdu_busy, pc_en); end
        tick();
    endtask

    task automatic test_mem_wait();
        for (int c = 0; c < 3; c++) begin
            apply(0, 0, 0, 0, 0, 0, 0, 1, 0);
            n_tests++; if (act_vec !== exp_vec || act_vec !== 9'b00001_0001) begin n_fail++;
                $display("FAIL mem_wait%0d: got %b expected %b", c, act_vec, 9'b00001_0001); end
            tick();
        end
        // MDU whose count expires under a memory wait: release must be deferred.
        for (int c = 0; c < MDU_CYCLES + 4; c++) begin
            apply(0, 0, 0, 0, 0, 0, 1, (c >= MDU_CYCLES && c < MDU_CYCLES + 2), 0);
            n_tests++; if (act_vec !== exp_vec || mdu_busy !== m_active) begin n_fail++;
                $display("FAIL mdu_mem_overlap%0d: got %b/%b expected %b/%b", c, act_vec, mdu_busy, exp_vec, m_active); end
            if (!m_active && c > 0) ex_mdu_start = 1'b0;
            tick();
        end
        apply(0, 0, 0, 0, 0, 0, 0, 0, 1);
        n_tests++; if (mdu_busy !== 1'b0 || act_vec !== 9'b11111_0000) begin n_fail++;
            $display("FAIL mdu_mem_release: got %b/%b expected %b/0", act_vec, mdu_busy, 9'b11111_0000); end
        tick();
    endtask

    task automatic test_reset_mid_mdu();
        apply(0, 0, 0, 0, 0, 0, 1, 0, 1);
        tick();
        apply(0, 0, 0, 0, 0, 0, 1, 0, 1);
        tick();
        reset = 1'b1;
        #1;
        n_tests++; if (act_vec !== 9'b0 || mdu_busy !== 1'b0) begin n_fail++;
            $display("FAIL reset_mid_mdu: got %b/%b expected %b/0", act_vec, mdu_busy, 9'b0); end
        m_active = 1'b0; m_age = 0; m_stall = 0; m_flush = 0;
        @(negedge clk);
        reset = 1'b0;
        apply(0, 0, 0, 0, 0, 0, 0, 0, 1);
        n_tests++; if (mdu_busy !== 1'b0 || act_vec !== 9'b11111_0000) begin n_fail++;
            $display("FAIL after_reset_mdu: got %b/%b expected %b/0", act_vec, mdu_busy, 9'b11111_0000); end
        tick();
    endtask

    task automatic test_perf();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            apply(8, 0, 0, 1, 8, 0, 0, 0, 1);
            tick();
        end
        apply(0, 0, 0, 0, 0, 1, 0, 0, 1);
        tick();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 1);
        n_tests++; if (perf_stall_cnt !== (PERF_ON ? 3 : 0) || perf_flush_cnt !== (PERF_ON ? 1 : 0)) begin n_fail++;
            $display("FAIL perf_counts: got %0d/%0d expected %0d/%0d", perf_stall_cnt, perf_flush_cnt,
                     PERF_ON ? 3 : 0, PERF_ON ? 1 : 0); end
        for (int c = 0; c < PERF_MAX + 8; c++) begin
            apply(0, 0, 0, 0, 0, 0, 0, 1, 0);
            tick();
        end
        apply(0, 0, 0, 0, 0, 0, 0, 0, 1);
        n_tests++; if (perf_stall_cnt !== (PERF_ON ? PERF_MAX : 0)) begin n_fail++;
            $display("FAIL perf_saturate: got %0d expected %0d", perf_stall_cnt, PERF_ON ? PERF_MAX : 0); end
        tick();
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            apply($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 3), ($urandom_range(0, 5) == 0),
                  m_active ? 1'b1 : ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 3) == 0), $urandom_range(0, 1));
            n_tests++; if (act_vec !== exp_vec || mdu_busy !== m_active) begin n_fail++;
                if (bad < 10) $display("FAIL rand_cycle%0d: got %b/%b expected %b/%b", c, act_vec, mdu_busy, exp_vec, m_active);
                bad++; end
            n_tests++; if (perf_stall_cnt !== (PERF_ON ? m_stall : 0) || perf_flush_cnt !== (PERF_ON ? m_flush : 0)) begin n_fail++;
                if (bad < 10) $display("FAIL rand_perf%0d: got %0d/%0d expected %0d/%0d", c, perf_stall_cnt, perf_flush_cnt,
                                       PERF_ON ? m_stall : 0, PERF_ON ? m_flush : 0);
                bad++; end
            tick();
        end
    endtask

    initial begin
        reset = 1'b1;
        id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; ex_memread = 1'b0; ex_rd_addr = '0;
        ex_branch_taken = 1'b0; ex_mdu_start = 1'b0; mem_req = 1'b0; mem_ready = 1'b1;
        m_active = 1'b0; m_age = 0; m_stall = 0; m_flush = 0;
        @(negedge clk);
        test_reset();
        test_load_use();
        test_branch();
        test_mdu();
        test_mem_wait();
        test_reset_mid_mdu();
        test_perf();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core.
- Generates per-stage enable (hold) and flush (bubble) strobes for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves four conditions: load-use hazards, taken-branch squashes, multi-cycle multiply/divide occupancy of EX, and data-memory wait states.
- Contains the MDU occupancy FSM/counter and optional performance counters.

Parameters:
- REG_AW, 5, register-address width.
- MDU_CYCLES, 32, total EX-freeze cycles per MDU operation; must be >= 2.
- CNT_W, 6, MDU down-counter width; must satisfy 2^CNT_W > MDU_CYCLES.
- PERF_W, 32, performance-counter width.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- id_rs  in  REG_AW  rs of instruction in ID
- id_rt  in  REG_AW  rt of instruction in ID
- id_uses_rt  in  1  ID instruction reads rt
- ex_memread  in  1  EX instruction is a load
- ex_rd_addr  in  REG_AW  destination register of EX instruction
- ex_branch_taken  in  1  branch/jump resolved taken in EX
- ex_mdu_start  in  1  EX holds a mult/div instruction
- mem_req  in  1  MEM stage is accessing data memory
- mem_ready  in  1  data memory completes this cycle
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register load enables
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  load a bubble (all-zero) this edge
- mdu_busy  out  1  FSM in MDU_BUSY
- perf_stall_cnt  out  PERF_W  cycles with pc_en=0
- perf_flush_cnt  out  PERF_W  taken-branch squashes

Behaviour:
- Reset state: FSM=RUN, mdu_cnt=0, perf counters=0. While reset is high, all enables=0 and all flushes=0.
- Outputs are combinational from state and inputs (Mealy). Only state, mdu_cnt and perf counters are registered.
- Condition priority, highest first:
  1. MEM_WAIT: mem_req & ~mem_ready.
     - pc/ifid/idex/exmem enables=0.
     - memwb_en=1 with memwb_flush=1.
     - All other flushes=0.
  2. MDU stall: (RUN & ex_mdu_start) or (MDU_BUSY & mdu_cnt!=0).
     - pc/ifid/idex enables=0.
     - exmem_en=1 with exmem_flush=1.
     - memwb_en=1.
  3. BRANCH: ex_branch_taken.
     - All enables=1.
     - ifid_flush=1, idex_flush=1.
     - The PC loads the target.
  4. LOAD_USE: ex_memread & ex_rd_addr!=0 & (ex_rd_addr==id_rs | (id_uses_rt & ex_rd_addr==id_rt)).
     - pc_en=0, ifid_en=0.
     - idex_en=1 with idex_flush=1.
     - exmem/memwb enables=1.
  5. Otherwise: all enables=1, all flushes=0.
- A flush is only ever asserted together with its register's enable.
- MDU FSM, states RUN and MDU_BUSY:
  - RUN & ex_mdu_start: load mdu_cnt=MDU_CYCLES-1, go to MDU_BUSY. This cycle is a stall cycle.
  - MDU_BUSY & mdu_cnt!=0: decrement. The counter keeps decrementing during MEM_WAIT.
  - MDU_BUSY & mdu_cnt==0 & ~MEM_WAIT: release (no MDU stall) and go to RUN. The MDU instruction leaves EX on this edge.
  - MDU_BUSY & mdu_cnt==0 & MEM_WAIT: hold state until the wait ends.
  - ex_mdu_start is ignored in MDU_BUSY, so a start still held during the release cycle does not retrigger.
  - Net effect: start first seen in cycle T leaves EX at the end of cycle T+MDU_CYCLES, provided there is no MEM_WAIT.
- A taken branch coinciding with load-use: the branch wins and no stall occurs.
- A taken branch during MEM_WAIT or an MDU stall: suppressed. It is re-evaluated once EX advances, since the branch is held in the frozen ID/EX.
- ex_rd_addr==0 never causes a load-use stall.
- Reset mid-MDU: FSM returns to RUN immediately and the counter clears.

Optional Feature:
- Macro PIPE_CTRL_PERF_EN.
- Defined:
  - perf_stall_cnt increments every non-reset cycle with pc_en=0.
  - perf_flush_cnt increments every cycle in which the BRANCH condition produces flushes.
  - Both counters saturate at all-ones and are cleared by reset.
- Undefined: both ports are present and tied to 0; no counter flops are synthesised.

Test Plan:
- Load-use: ex_memread=1, ex_rd_addr=8, id_rs=8 -> one cycle with pc_en=0, ifid_en=0, idex_flush=1. With ex_rd_addr=0 -> no stall.
- Branch: ex_branch_taken=1 -> ifid_flush=idex_flush=1, pc_en=1. With simultaneous load-use -> same result, pc_en=1.
- MDU, MDU_CYCLES=4: ex_mdu_start held high from cycle T -> pc_en=0 and exmem_flush=1 for cycles T..T+3. Release at T+4 with mdu_busy falling. No retrigger.
- MEM_WAIT: mem_req=1, mem_ready=0 for 3 cycles -> pc/ifid/idex/exmem enables=0, memwb_flush=1 for 3 cycles. Overlapping an MDU whose count expires -> release deferred until mem_ready=1.
- Reset asserted mid-MDU (mdu_cnt=2) -> all outputs 0 immediately. After deassert: RUN, mdu_busy=0.
- PIPE_CTRL_PERF_EN: 3 stall cycles plus 1 branch -> perf_stall_cnt=3, perf_flush_cnt=1. Counter preloaded near saturation holds at all-ones.
